mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single-ported 1024×32 unified memory of the `mips_32` core between two requesters: the instruction-fetch stage (read-only) and the load/store data stage (read/write). It sits between the pipeline and the memory array. It serialises accesses through a small FSM with configurable memory wait states. Data requests have fixed priority, and a starvation counter bounds fetch latency.

## Interface
- `AW`, 10, memory word-address width
- `DW`, 32, data width
- `WAIT_STATES`, 0, extra memory read latency cycles (0..7)
- `STARVE_MAX`, 4, consecutive DM grants allowed while IF is waiting (1..15)

- `clk1` in 1: single clock, rising edge; the block uses one clock only.
- `rst` in 1: asynchronous, active-high reset.
- `if_req` in 1: fetch read request.
- `if_addr` in AW: fetch address.
- `if_gnt` out 1: fetch request accepted (1-cycle pulse).
- `if_rvalid` out 1: fetch data valid (1-cycle pulse).
- `if_rdata` out DW: fetch data.
- `dm_req` in 1: data request.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_addr` in AW: data address.
- `dm_wdata` in DW: data write data.
- `dm_gnt` out 1: data request accepted (pulse).
- `dm_rvalid` out 1: data read valid (pulse, reads only).
- `dm_rdata` out DW: data read data.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data. Valid WAIT_STATES+1 cycles after the `mem_en` cycle.
- `busy` out 1: access in flight.
- `ld_req`, `ld_addr`, `ld_wdata`, `ld_gnt`, `ld_active`: present only with the loader macro (see Configuration).

## Operation
- FSM states are IDLE, ACCESS and WAIT.
- IDLE: sample requests at the clock edge and pick a winner. If a request wins, go to ACCESS; otherwise stay in IDLE.
- Arbitration priority is DM over IF. Exception: when `starve_cnt == STARVE_MAX` and both requesters are asserting, IF wins.
- `starve_cnt` increments on each DM grant while `if_req` is high. It clears on an IF grant or whenever `if_req` is low.
- The counter saturates at STARVE_MAX.
- ACCESS (1 cycle):
  - assert `*_gnt` for the winner;
  - drive `mem_en=1`, `mem_addr`, and for writes `mem_we=1` and `mem_wdata`.
  - A write returns to IDLE.
  - A read goes to WAIT.
- WAIT lasts WAIT_STATES+1 cycles.
  - At the edge ending WAIT, capture `mem_rdata` into the winner's `*_rdata`.
  - Pulse the winner's `*_rvalid` in the following cycle, which is an IDLE cycle.
  - Return to IDLE.
- Requester rules:
  - A requester holds `req`, `addr`, `we` and `wdata` stable until it sees `gnt`.
  - A requester may drop `req` before `gnt`; this has no side effect.
  - A requester may change its inputs freely after `gnt`.
- Only one access is ever outstanding.
- `*_rdata` holds its value until the next capture for that requester.

## Timing
- All outputs are registered.
- Reset value of every output is 0. On reset the FSM goes to IDLE and `starve_cnt` clears to 0.
- Reset asserted mid-access aborts the access: no `rvalid` is produced, and no write occurs unless its `mem_en` cycle has already completed.
- Request asserted in cycle 0:
  - `gnt` and `mem_en` in cycle 1;
  - read `rvalid` in cycle 3+WAIT_STATES.
- Back-to-back accesses:
  - A new grant is possible in the cycle after the `rvalid` cycle (read) or 2 cycles after the previous grant (write).
  - The `rvalid` IDLE cycle is itself an arbitration cycle.
- If IF and DM requests arrive in the same cycle with `starve_cnt < STARVE_MAX`, only `dm_gnt` pulses. IF keeps `if_req` asserted and waits.
- `busy` is 1 exactly in the ACCESS and WAIT states.

## Configuration
- Macro: `MEM_ARB_LOADER_EN`.
- With the macro defined:
  - Adds a write-only program-loader requester: ports `ld_req` (in 1), `ld_addr` (in AW), `ld_wdata` (in DW) and `ld_gnt` (out 1).
  - The loader has highest priority, above DM and above the starvation override.
  - `ld_active` (out 1, reset 0) is 1 from the first `ld_gnt` until a cycle with `ld_req` low in IDLE.
  - Loader grants do not change `starve_cnt`.
- Without the macro: the loader ports are absent and the logic is removed.

## Structure
- Shared package `mips_pkg`:
  - `arb_state_t` {ARB_IDLE, ARB_ACCESS, ARB_WAIT};
  - `req_id_t` {REQ_NONE, REQ_IF, REQ_DM, REQ_LD};
  - constants `MEM_AW=10` and `MEM_DW=32`.
- Sub-module `arb_prio_pick`: purely combinational winner selection from the request vector and the starvation flag. The top module owns the FSM, the counters and the registers.

## Test plan
- `rst` pulsed during WAIT of a read of address 0x005: all outputs are 0, and no `if_rvalid` occurs after release.
- WAIT_STATES=1, `Mem[0x005]=0x12345678`, IF read in cycle 0:
  - `if_gnt`, `mem_en` and `mem_addr=0x005` in cycle 1;
  - `if_rvalid=1`, `if_rdata=0x12345678` in cycle 4.
- DM write of 0xDEADBEEF to 0x3FF in cycle 0, then a DM read of 0x3FF:
  - `mem_we=1` in cycle 1;
  - the read returns 0xDEADBEEF with `dm_rvalid`.
- STARVE_MAX=2, both requesting continuous reads: grant order is DM, DM, IF, DM, DM, IF, and no IF wait exceeds 2 DM accesses.
- `MEM_ARB_LOADER_EN`, `ld_req` asserted with `if_req` and `dm_req`: `ld_gnt` is granted first, `ld_active=1`, and `starve_cnt` is unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and memory geometry for the mips_32 memory port arbiter
package mips_pkg;

    localparam int MEM_AW = 10;
    localparam int MEM_DW = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_WAIT} arb_state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_IF, REQ_DM, REQ_LD} req_id_t;

endpackage

// File: rtl/arb_prio_pick.sv
// rtl/arb_prio_pick.sv - combinational winner selection: LD > (starved ? IF : DM) > IF
module arb_prio_pick
    import mips_pkg::*;
(
    input  logic [2:0] req,      // {ld, dm, if}
    input  logic       starved,
    output req_id_t    winner
);

    always_comb begin
        winner = REQ_NONE;
        if (req[2]) begin
            winner = REQ_LD;
        end else if (req[1] && req[0]) begin
            winner = starved ? REQ_IF : REQ_DM;
        end else if (req[1]) begin
            winner = REQ_DM;
        end else if (req[0]) begin
            winner = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises IF/DM accesses onto the single-ported mips_32 memory
// Optional write-only program loader requester enabled by MEM_ARB_LOADER_EN
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int AW          = MEM_AW,
    parameter int DW          = MEM_DW,
    parameter int WAIT_STATES = 0,
    parameter int STARVE_MAX  = 4
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
`ifdef MEM_ARB_LOADER_EN
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_active,
`endif
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    localparam logic [2:0] WS   = 3'(WAIT_STATES);

    arb_state_t    state;
    req_id_t       owner;
    req_id_t       pick;
    logic          owner_we;
    logic [2:0]    wait_cnt;
    logic [3:0]    starve_cnt;
    logic          ld_req_i;
    logic [AW-1:0] ld_addr_i;
    logic [DW-1:0] ld_wdata_i;

`ifdef MEM_ARB_LOADER_EN
    assign ld_req_i   = ld_req;
    assign ld_addr_i  = ld_addr;
    assign ld_wdata_i = ld_wdata;
`else
    assign ld_req_i   = 1'b0;
    assign ld_addr_i  = '0;
    assign ld_wdata_i = '0;
`endif

    arb_prio_pick u_pick (
        .req     ({ld_req_i, dm_req, if_req}),
        .starved (starve_cnt == SMAX),
        .winner  (pick)
    );

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= REQ_NONE;
            owner_we   <= 1'b0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_gnt     <= 1'b0;
            dm_rvalid  <= 1'b0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            // A fetch that is not asking cannot be starved
            if (!if_req) starve_cnt <= '0;

            unique case (state)
                ARB_IDLE: begin
                    if (pick != REQ_NONE) begin
                        state  <= ARB_ACCESS;
                        owner  <= pick;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        case (pick)
                            REQ_IF: begin
                                if_gnt     <= 1'b1;
                                mem_addr   <= if_addr;
                                owner_we   <= 1'b0;
                                starve_cnt <= '0;
                            end
                            REQ_DM: begin
                                dm_gnt    <= 1'b1;
                                mem_addr  <= dm_addr;
                                mem_we    <= dm_we;
                                mem_wdata <= dm_wdata;
                                owner_we  <= dm_we;
                                if (if_req && starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
                            end
                            REQ_LD: begin
                                mem_addr  <= ld_addr_i;
                                mem_we    <= 1'b1;
                                mem_wdata <= ld_wdata_i;
                                owner_we  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ARB_ACCESS: begin
                    if (owner_we) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= ARB_WAIT;
                        wait_cnt <= WS;
                    end
                end
                ARB_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ARB_IDLE;
                        busy  <= 1'b0;
                        if (owner == REQ_IF) begin
                            if_rdata  <= mem_rdata;
                            if_rvalid <= 1'b1;
                        end else begin
                            dm_rdata  <= mem_rdata;
                            dm_rvalid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_LOADER_EN
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ld_gnt    <= 1'b0;
            ld_active <= 1'b0;
        end else begin
            ld_gnt <= (state == ARB_IDLE) && (pick == REQ_LD);
            if ((state == ARB_IDLE) && (pick == REQ_LD)) begin
                ld_active <= 1'b1;
            end else if ((state == ARB_IDLE) && !ld_req) begin
                ld_active <= 1'b0;
            end
        end
    end
`endif

endmodule
